key_conditioner: RTL and testbench

Converts the three raw, active-low, bouncing DE0 push-buttons into clean single-cycle press pulses for the downstream ABBAC sequence recogniser. Each key goes through a two-flop synchroniser, a debounce state machine with a press and a release qualification period, and a shared output arbiter. The arbiter guarantees at most one pulse per cycle and exactly one pulse per physical press. Pulse[2], Pulse[1] and Pulse[0] drive the recogniser's A, B and C inputs.

---
 rtl/key_pkg.sv | 13 +
 rtl/key_debounce.sv | 83 ++++++++
 rtl/key_conditioner.sv | 60 ++++++
 tb/tb_key_conditioner.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_PRESS_WAIT,
        KEY_HELD,
        KEY_REL_WAIT
    } key_state_t;

    localparam int KEY_DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser, press/release debounce FSM, held level and
// a single-cycle qualify strobe when a press is accepted.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic button_i,
    output logic held_o,
    output logic qualify_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          held_q, held_d;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= KEY_IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

    // sync2_q is the synchronised level: 0 = pressed
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qualify_o = 1'b0;
        case (state_q)
            KEY_IDLE: begin
                if (!sync2_q) begin
                    state_d = KEY_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            KEY_PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = KEY_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = KEY_HELD;
                    qualify_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KEY_HELD: begin
                if (sync2_q) begin
                    state_d = KEY_REL_WAIT;
                    cnt_d   = '0;
                end
            end
            KEY_REL_WAIT: begin
                if (!sync2_q) begin
                    state_d = KEY_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KEY_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = KEY_IDLE;
        endcase
        held_d = (state_d == KEY_HELD) || (state_d == KEY_REL_WAIT);
    end

    assign held_o = held_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounces N_KEYS active-low buttons and serialises accepted presses into
// one-hot single-cycle pulses, highest key index first.
module key_conditioner
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int N_KEYS          = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [N_KEYS-1:0] Button,
    output logic [N_KEYS-1:0] Pulse,
    output logic [N_KEYS-1:0] Held
);

    logic [N_KEYS-1:0] qualify;
    logic [N_KEYS-1:0] held_w;
    logic [N_KEYS-1:0] pending_q, pending_d;
    logic [N_KEYS-1:0] pulse_q, grant_d;
    logic              found;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .Clock    (Clock),
            .Resetn   (Resetn),
            .button_i (Button[g]),
            .held_o   (held_w[g]),
            .qualify_o(qualify[g])
        );
    end

    // A key that qualifies while its bit is still pending merges into it.
    always_comb begin
        grant_d = '0;
        found   = 1'b0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pending_q[i] && !found) begin
                grant_d[i] = 1'b1;
                found      = 1'b1;
            end
        end
        pending_d = (pending_q & ~grant_d) | qualify;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pending_q <= '0;
            pulse_q   <= '0;
        end else begin
            pending_q <= pending_d;
            pulse_q   <= grant_d;
        end
    end

    assign Pulse = pulse_q;
    assign Held  = held_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Scenario bench for key_conditioner with DEBOUNCE_CYCLES=4; expected pulses
// are queued with their due cycle and matched by a monitor.
module tb_key_conditioner;

    localparam int D = 4;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [2:0] Button = 3'b111;
    logic [2:0] Pulse, Held;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    key_conditioner #(.DEBOUNCE_CYCLES(D), .N_KEYS(3)) dut (
        .Clock (Clock),
        .Resetn(Resetn),
        .Button(Button),
        .Pulse (Pulse),
        .Held  (Held)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // every nonzero Pulse must match the head of the scoreboard exactly
    always @(negedge Clock) begin
        if (Resetn && Pulse !== 3'b000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b want none", cyc, Pulse);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc !== cyc || e.val !== Pulse) begin
                    errors++;
                    $display("FAIL pulse_match got cyc=%0d val=%b want cyc=%0d val=%b",
                             cyc, Pulse, e.cyc, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    task automatic check_sb_empty(input string nm);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses got=%0d pending want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Button = 3'b111;
        repeat (20) begin
            @(negedge Clock);
            checks++;
            if (Pulse !== 3'b000 || Held !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold got pulse=%b held=%b want 000/000", Pulse, Held);
            end
        end
        Resetn = 1'b1;
        repeat (20) @(negedge Clock);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_held got=%b want 000", Held);
        end
        check_sb_empty("reset");
    endtask

    task automatic test_single();
        int k, m;
        @(negedge Clock);
        Button[2] = 1'b0;
        k = cyc + 1;
        sb.push_back('{k + D + 3, 3'b100});
        wait_until(k + D + 1);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL single_held_early got=%b want 000", Held);
        end
        wait_until(k + D + 2);
        checks++;
        if (Held !== 3'b100) begin
            errors++;
            $display("FAIL single_held_rise got=%b want 100", Held);
        end
        wait_until(k + 19);
        Button[2] = 1'b1;
        m = cyc + 1;
        wait_until(m + D + 1);
        checks++;
        if (Held !== 3'b100) begin
            errors++;
            $display("FAIL single_held_before_fall got=%b want 100", Held);
        end
        wait_until(m + D + 2);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL single_held_fall got=%b want 000", Held);
        end
        repeat (6) @(negedge Clock);
        check_sb_empty("single");
    endtask

    task automatic test_bounce();
        @(negedge Clock);
        Button[1] = 1'b0;
        repeat (3) @(negedge Clock);
        Button[1] = 1'b1;
        repeat (2) @(negedge Clock);
        Button[1] = 1'b0;
        repeat (3) @(negedge Clock);
        Button[1] = 1'b1;
        repeat (15) begin
            @(negedge Clock);
            checks++;
            if (Held !== 3'b000) begin
                errors++;
                $display("FAIL bounce_held got=%b want 000", Held);
            end
        end
        check_sb_empty("bounce");
    endtask

    task automatic test_contention();
        int k;
        @(negedge Clock);
        Button = 3'b010;
        k = cyc + 1;
        sb.push_back('{k + D + 3, 3'b100});
        sb.push_back('{k + D + 4, 3'b001});
        wait_until(k + D + 1);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL contention_held_early got=%b want 000", Held);
        end
        wait_until(k + D + 2);
        checks++;
        if (Held !== 3'b101) begin
            errors++;
            $display("FAIL contention_held got=%b want 101", Held);
        end
        wait_until(k + 14);
        checks++;
        if (Held !== 3'b101) begin
            errors++;
            $display("FAIL contention_held_late got=%b want 101", Held);
        end
        Button = 3'b111;
        repeat (12) @(negedge Clock);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL contention_release got=%b want 000", Held);
        end
        check_sb_empty("contention");
    endtask

    task automatic test_release_bounce();
        int k, m;
        @(negedge Clock);
        Button[1] = 1'b0;
        k = cyc + 1;
        sb.push_back('{k + D + 3, 3'b010});
        wait_until(k + 11);
        Button[1] = 1'b1;
        repeat (2) @(negedge Clock);
        Button[1] = 1'b0;
        @(negedge Clock);
        Button[1] = 1'b1;
        m = cyc + 1;
        while (cyc < m + D + 1) begin
            @(negedge Clock);
            checks++;
            if (Held !== 3'b010) begin
                errors++;
                $display("FAIL relbounce_held cyc=%0d got=%b want 010", cyc, Held);
            end
        end
        wait_until(m + D + 2);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL relbounce_fall got=%b want 000", Held);
        end
        wait_until(m + 10);
        check_sb_empty("relbounce");
    endtask

    task automatic test_reset_mid();
        int k, r;
        @(negedge Clock);
        Button[0] = 1'b0;
        k = cyc + 1;
        wait_until(k + 3);
        Resetn = 1'b0;
        #1;
        checks++;
        if (Pulse !== 3'b000 || Held !== 3'b000) begin
            errors++;
            $display("FAIL midreset_clear got pulse=%b held=%b want 000/000", Pulse, Held);
        end
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        r = cyc + 1;
        sb.push_back('{r + D + 3, 3'b001});
        wait_until(r + D + 1);
        checks++;
        if (Held !== 3'b000) begin
            errors++;
            $display("FAIL midreset_held_early got=%b want 000", Held);
        end
        wait_until(r + D + 2);
        checks++;
        if (Held !== 3'b001) begin
            errors++;
            $display("FAIL midreset_held got=%b want 001", Held);
        end
        wait_until(r + 12);
        Button[0] = 1'b1;
        repeat (10) @(negedge Clock);
        check_sb_empty("midreset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_bounce();
        test_contention();
        test_release_bounce();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
